// File: rtl/btn_reader_pkg.sv
// Shared game package: button-reader defaults, index width helper and
// the output-stage state encoding.
package btn_reader_pkg;

    localparam int NUM_BTN_DEF   = 4;
    localparam int DEB_COUNT_DEF = 4;

    // Index width for n buttons; a single button still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(NUM_BTN_DEF);

    // Output stage holds at most one press for the consumer.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/btn_reader_if.sv
// Press handshake between the button reader (master) and the game FSM
// (slave), plus the sticky overrun flag and its clear.
interface btn_reader_if
    import btn_reader_pkg::*;
#(
    parameter int IDX_W = btn_reader_pkg::IDX_W
);
    logic             press_valid;
    logic [IDX_W-1:0] press_idx;
    logic             press_ready;
    logic             overrun;
    logic             clr_overrun;

    modport master (
        output press_valid,
        output press_idx,
        output overrun,
        input  press_ready,
        input  clr_overrun
    );

    modport slave (
        input  press_valid,
        input  press_idx,
        input  overrun,
        output press_ready,
        output clr_overrun
    );
endinterface

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchronizer, tick-driven debounce counter and
// a one-cycle strobe on each accepted 0->1 transition.
module btn_debounce
    import btn_reader_pkg::*;
#(
    parameter int DEB_COUNT = DEB_COUNT_DEF,
    localparam int CW = $clog2(DEB_COUNT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic read_tick,
    input  logic btn_raw,
    output logic strobe
);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Synchronizer every cycle; debounce only on read ticks. The counter
    // toggles the level on the tick that would bring it to DEB_COUNT, and
    // the strobe fires on that same edge only for a rising level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync   <= '0;
            level  <= 1'b0;
            cnt    <= '0;
            strobe <= 1'b0;
        end else begin
            sync   <= {sync[0], btn_raw};
            strobe <= 1'b0;
            if (read_tick) begin
                if (sync[1] != level) begin
                    if (cnt == CW'(DEB_COUNT - 1)) begin
                        level  <= ~level;
                        cnt    <= '0;
                        strobe <= ~level;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/btn_reader.sv
// Button reader: NUM_BTN debouncers feeding a lowest-index priority pick
// and a single-entry output register with a valid/ready handshake and a
// sticky overrun flag for presses that could not be held.
module btn_reader
    import btn_reader_pkg::*;
#(
    parameter int NUM_BTN   = NUM_BTN_DEF,
    parameter int DEB_COUNT = DEB_COUNT_DEF,
    localparam int IW = idx_width(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_tick,
    input  logic [NUM_BTN-1:0] btn_raw,
    btn_reader_if.master       bus
);

    logic [NUM_BTN-1:0] strobe;
    logic [NUM_BTN-1:0] sel_onehot;
    logic [IW-1:0]      sel_idx;
    logic               any_strobe;

    out_state_t         state, state_nxt;
    logic [IW-1:0]      idx_q, idx_nxt;
    logic               ovr_q, ovr_nxt;
    logic               lost;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEB_COUNT (DEB_COUNT)
        ) u_deb (
            .clk       (clk),
            .rst       (rst),
            .read_tick (read_tick),
            .btn_raw   (btn_raw[g]),
            .strobe    (strobe[g])
        );
    end

    assign any_strobe = |strobe;
    // Isolate the lowest set strobe bit.
    assign sel_onehot = strobe & (~strobe + NUM_BTN'(1));

    // Priority encode: lowest strobing index wins.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (strobe[i]) sel_idx = IW'(i);
        end
    end

    // Output stage next state: load, drain or drop, and flag any loss.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        lost      = 1'b0;
        case (state)
            EMPTY: begin
                if (any_strobe) begin
                    state_nxt = FULL;
                    idx_nxt   = sel_idx;
                    lost      = |(strobe & ~sel_onehot);
                end
            end
            FULL: begin
                if (bus.press_ready) begin
                    if (any_strobe) begin
                        idx_nxt = sel_idx;
                        lost    = |(strobe & ~sel_onehot);
                    end else begin
                        state_nxt = EMPTY;
                    end
                end else begin
                    // Held press stays stable; everything new is dropped.
                    lost = any_strobe;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // A loss in the same cycle as a clear keeps the flag set.
        if (lost)                 ovr_nxt = 1'b1;
        else if (bus.clr_overrun) ovr_nxt = 1'b0;
        else                      ovr_nxt = ovr_q;
    end

    // Output stage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            idx_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            state <= state_nxt;
            idx_q <= idx_nxt;
            ovr_q <= ovr_nxt;
        end
    end

    assign bus.press_valid = (state == FULL);
    assign bus.press_idx   = idx_q;
    assign bus.overrun     = ovr_q;

endmodule
